lc3_mmio: RTL and testbench

Memory-mapped I/O stage on the LC3 memory bus, between the processor's mar/mdr/memwe/memOut signals and the data memory.
- Decodes the four LC3 device registers: KBSR, KBDR, DSR, DDR.
- Buffers incoming keyboard characters in a small FIFO.
- Drives a valid/ack display output channel.
- Suppresses memory writes to I/O addresses. The top level muxes ioOut onto memOut whenever io_sel is high.

---
 rtl/lc3_mmio.sv | 183 ++++++++++++++++++
 tb/tb_lc3_mmio.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mmio.sv
// LC3 memory-mapped I/O stage: decodes KBSR/KBDR/DSR/DDR, buffers keyboard
// characters in a small FIFO, drives a valid/ack display channel and keeps
// I/O stores away from the data memory.
module lc3_mmio #(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int KBD_FIFO_DEPTH  = 4,
    parameter int DSP_BUSY_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] mar,
    input  logic [15:0]              mdr,
    input  logic                     memwe,
    input  logic                     memre,
    output logic                     io_sel,
    output logic [15:0]              ioOut,
    output logic                     mem_we_gated,
    input  logic                     kbd_valid,
    input  logic [7:0]               kbd_data,
    output logic                     kbd_ready,
    output logic                     kbd_irq,
    output logic                     dsp_valid,
    output logic [7:0]               dsp_data,
    input  logic                     dsp_ack
);

    localparam int PTR_W  = $clog2(KBD_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BUSY_W = $clog2(DSP_BUSY_CYCLES + 1);

    localparam logic [ADDRESS_WIDTH-1:0] KBSR_ADDR = ADDRESS_WIDTH'(16'hFE00);
    localparam logic [ADDRESS_WIDTH-1:0] KBDR_ADDR = ADDRESS_WIDTH'(16'hFE02);
    localparam logic [ADDRESS_WIDTH-1:0] DSR_ADDR  = ADDRESS_WIDTH'(16'hFE04);
    localparam logic [ADDRESS_WIDTH-1:0] DDR_ADDR  = ADDRESS_WIDTH'(16'hFE06);

    // Display channel states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Address decode
    logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
    assign hit_kbsr = (mar == KBSR_ADDR);
    assign hit_kbdr = (mar == KBDR_ADDR);
    assign hit_dsr  = (mar == DSR_ADDR);
    assign hit_ddr  = (mar == DDR_ADDR);

    assign io_sel       = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;
    assign mem_we_gated = memwe & ~io_sel;

    // Only mdr[14] (KBSR.IE) and mdr[7:0] (DDR character) are ever written.
    logic unused_mdr;
    assign unused_mdr = ^{mdr[15], mdr[13:8]};

    // Keyboard FIFO state
    logic [7:0]       fifo_mem [KBD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic             kbsr_ie;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(KBD_FIFO_DEPTH));
    assign kbd_ready  = ~fifo_full;
    assign kbd_irq    = kbsr_ie & ~fifo_empty;

    // A pop on an empty FIFO is ignored even if a push lands in the same cycle,
    // so the load sees 0x0000 and the new character stays queued.
    assign push = kbd_valid & ~fifo_full;
    assign pop  = memre & hit_kbdr & ~fifo_empty;

    // Display channel state
    logic [1:0]        dsp_state;
    logic [BUSY_W-1:0] busy_cnt;
    logic              dsr_ready;
    logic              dsr_ovr;
    logic              ddr_write;

    assign dsr_ready = (dsp_state == ST_IDLE);
    assign ddr_write = memwe & hit_ddr;

    // FIFO storage: write the incoming character into the tail slot
    // NOTE: the storage array has no reset; fifo_count alone says which slots
    // hold data, and leaving it unreset lets it map onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= kbd_data;
        end
    end

    // FIFO pointers and occupancy count
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample pre-edge values; blocking here would make results order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // KBSR interrupt enable: the only writable status bit
    always_ff @(posedge clk) begin
        if (reset) begin
            kbsr_ie <= 1'b0;
        end else if (memwe && hit_kbsr) begin
            kbsr_ie <= mdr[14];
        end
    end

    // Display handshake FSM: latch on DDR write, hold until ack, then stay busy
    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_state <= ST_IDLE;
            dsp_valid <= 1'b0;
            dsp_data  <= 8'h00;
            busy_cnt  <= '0;
        end else begin
            case (dsp_state)
                ST_IDLE: begin
                    if (ddr_write) begin
                        dsp_data  <= mdr[7:0];
                        dsp_valid <= 1'b1;
                        dsp_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (dsp_ack) begin
                        dsp_valid <= 1'b0;
                        busy_cnt  <= BUSY_W'(DSP_BUSY_CYCLES - 1);
                        dsp_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (busy_cnt == '0) begin
                        dsp_state <= ST_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt - BUSY_W'(1);
                    end
                end
                default: begin
                    dsp_state <= ST_IDLE;
                    dsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag: a DDR write while busy sets it, a DSR load clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            dsr_ovr <= 1'b0;
        end else if (ddr_write && !dsr_ready) begin
            dsr_ovr <= 1'b1;
        end else if (memre && hit_dsr) begin
            dsr_ovr <= 1'b0;
        end
    end

    // Device read mux, valid in the same cycle as mar
    // NOTE: ioOut gets a default before the branches so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ioOut = 16'h0000;
        if (hit_kbsr) begin
            ioOut = {~fifo_empty, kbsr_ie, 14'b0};
        end else if (hit_kbdr) begin
            ioOut = fifo_empty ? 16'h0000 : {8'h00, fifo_mem[rd_ptr]};
        end else if (hit_dsr) begin
            ioOut = {dsr_ready, 14'b0, dsr_ovr};
        end
    end

endmodule

// File: tb/tb_lc3_mmio.sv
// Self-checking bench for lc3_mmio: a table of per-cycle vectors followed by
// hand-written sequences for display latency, full-FIFO pop and reset cases.
module tb_lc3_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mar, mdr;
    logic        memwe, memre;
    logic        io_sel;
    logic [15:0] ioOut;
    logic        mem_we_gated;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready, kbd_irq;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ack;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lc3_mmio #(
        .ADDRESS_WIDTH  (16),
        .KBD_FIFO_DEPTH (4),
        .DSP_BUSY_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mar         (mar),
        .mdr         (mdr),
        .memwe       (memwe),
        .memre       (memre),
        .io_sel      (io_sel),
        .ioOut       (ioOut),
        .mem_we_gated(mem_we_gated),
        .kbd_valid   (kbd_valid),
        .kbd_data    (kbd_data),
        .kbd_ready   (kbd_ready),
        .kbd_irq     (kbd_irq),
        .dsp_valid   (dsp_valid),
        .dsp_data    (dsp_data),
        .dsp_ack     (dsp_ack)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] a;
        logic [15:0] d;
        logic        we;
        logic        re;
        logic        kv;
        logic [7:0]  kd;
        logic        ack;
        logic [28:0] exp;   // {io_sel, ioOut, mem_we_gated, kbd_ready, kbd_irq, dsp_valid, dsp_data}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic rst, input logic [15:0] a, input logic [15:0] d,
                         input logic we, input logic re, input logic kv,
                         input logic [7:0] kd, input logic ack);
        reset     = rst;
        mar       = a;
        mdr       = d;
        memwe     = we;
        memre     = re;
        kbd_valid = kv;
        kbd_data  = kd;
        dsp_ack   = ack;
    endtask

    task automatic add(input string n, input logic rst, input logic [15:0] a,
                       input logic [15:0] d, input logic we, input logic re,
                       input logic kv, input logic [7:0] kd, input logic ack,
                       input logic e_sel, input logic [15:0] e_out, input logic e_weg,
                       input logic e_rdy, input logic e_irq, input logic e_v,
                       input logic [7:0] e_d);
        vec_t v;
        v.name = n; v.rst = rst; v.a = a; v.d = d; v.we = we; v.re = re;
        v.kv = kv; v.kd = kd; v.ack = ack;
        v.exp = {e_sel, e_out, e_weg, e_rdy, e_irq, e_v, e_d};
        vecs.push_back(v);
    endtask

    function automatic logic [28:0] observed();
        return {io_sel, ioOut, mem_we_gated, kbd_ready, kbd_irq, dsp_valid, dsp_data};
    endfunction

    // Bound the whole run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        bit done;

        // name            rst  mar      mdr      we re kv kd     ack | sel ioOut    weg rdy irq v  data
        add("rst_dsr",      1, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h8000, 0, 1, 0, 0, 8'h00);
        add("rst_mem",      1, 16'h3000, 16'h0000, 1, 0, 0, 8'h00, 0,   0, 16'h0000, 1, 1, 0, 0, 8'h00);
        add("mem_wr",       0, 16'h3000, 16'h1234, 1, 0, 0, 8'h00, 0,   0, 16'h0000, 1, 1, 0, 0, 8'h00);
        add("push41",       0, 16'h0000, 16'h0000, 0, 0, 1, 8'h41, 0,   0, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("push42",       0, 16'h0000, 16'h0000, 0, 0, 1, 8'h42, 0,   0, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("push43",       0, 16'h0000, 16'h0000, 0, 0, 1, 8'h43, 0,   0, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("push44",       0, 16'h0000, 16'h0000, 0, 0, 1, 8'h44, 0,   0, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("full_kbsr",    0, 16'hFE00, 16'h0000, 0, 0, 1, 8'h45, 0,   1, 16'h8000, 0, 0, 0, 0, 8'h00);
        add("pop41",        0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0,   1, 16'h0041, 0, 0, 0, 0, 8'h00);
        add("pop42",        0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0,   1, 16'h0042, 0, 1, 0, 0, 8'h00);
        add("pop43",        0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0,   1, 16'h0043, 0, 1, 0, 0, 8'h00);
        add("pop44",        0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0,   1, 16'h0044, 0, 1, 0, 0, 8'h00);
        add("pop_empty",    0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("kbsr_empty",   0, 16'hFE00, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("kbdr_wr",      0, 16'hFE02, 16'h00AA, 1, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("kbsr_wr",      0, 16'hFE00, 16'h4000, 1, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("ie_push61",    0, 16'hFE00, 16'h0000, 0, 0, 1, 8'h61, 0,   1, 16'h4000, 0, 1, 0, 0, 8'h00);
        add("irq_set",      0, 16'hFE00, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'hC000, 0, 1, 1, 0, 8'h00);
        add("pop61",        0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0,   1, 16'h0061, 0, 1, 1, 0, 8'h00);
        add("irq_clr",      0, 16'hFE00, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h4000, 0, 1, 0, 0, 8'h00);
        add("ddr_wr",       0, 16'hFE06, 16'h1257, 1, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 0, 8'h00);
        add("send_wait0",   0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 1, 8'h57);
        add("send_wait1",   0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 1, 8'h57);
        add("send_wait2",   0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 1, 8'h57);
        add("send_wait3",   0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 1, 8'h57);
        add("send_wait4",   0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 1, 8'h57);
        add("ddr_ovr",      0, 16'hFE06, 16'h0058, 1, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 1, 8'h57);
        add("ovr_set",      0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0001, 0, 1, 0, 1, 8'h57);
        add("dsr_wr",       0, 16'hFE04, 16'hFFFF, 1, 0, 0, 8'h00, 0,   1, 16'h0001, 0, 1, 0, 1, 8'h57);
        add("ovr_rd",       0, 16'hFE04, 16'h0000, 0, 1, 0, 8'h00, 0,   1, 16'h0001, 0, 1, 0, 1, 8'h57);
        add("ovr_clr",      0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0,   1, 16'h0000, 0, 1, 0, 1, 8'h57);

        drive(1, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].a, vecs[i].d, vecs[i].we, vecs[i].re,
                  vecs[i].kv, vecs[i].kd, vecs[i].ack);
            #2;
            check(vecs[i].name, {3'b000, observed()}, {3'b000, vecs[i].exp});
        end

        // Ack, then DSR ready must return exactly 8 edges after the ack edge;
        // an ack pulse during HOLD must not disturb the countdown.
        @(negedge clk); drive(0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 1); #2;
        check("ack_valid_before", 32'(dsp_valid), 32'd1);
        @(negedge clk); drive(0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0); #2;
        check("ack_valid_drop", 32'(dsp_valid), 32'd0);
        check("ack_data_kept", 32'(dsp_data), 32'h57);
        check("hold_busy", 32'(ioOut), 32'h0000);
        edges = 0;
        done  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            dsp_ack = (i == 2);
            #2;
            edges++;
            if (ioOut == 16'h8000) done = 1'b1;
        end
        check("ready_latency", edges, 32'd8);
        dsp_ack = 1'b0;

        // Full FIFO: a simultaneous offer and pop does not push this cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(0, 16'h0000, 16'h0000, 0, 0, 1, 8'(8'h71 + i), 0);
        end
        @(negedge clk); drive(0, 16'hFE02, 16'h0000, 0, 1, 1, 8'h75, 0); #2;
        check("full_ready", 32'(kbd_ready), 32'd0);
        check("full_pop_head", 32'(ioOut), 32'h0071);
        @(negedge clk); drive(0, 16'hFE00, 16'h0000, 0, 0, 0, 8'h00, 0); #2;
        check("ready_after_pop", 32'(kbd_ready), 32'd1);
        check("kbsr_after_pop", 32'(ioOut), 32'hC000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0); #2;
            check("drain", 32'(ioOut), 32'h72 + i);
        end
        @(negedge clk); drive(0, 16'hFE02, 16'h0000, 0, 1, 0, 8'h00, 0); #2;
        check("no_push_while_full", 32'(ioOut), 32'h0000);

        // Reset during HOLD with a character queued
        @(negedge clk); drive(0, 16'hFE06, 16'h0033, 1, 0, 1, 8'h99, 0);
        @(negedge clk); drive(0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 1); #2;
        check("send_before_rst", 32'(dsp_valid), 32'd1);
        @(negedge clk); drive(0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0); #2;
        check("in_hold", 32'(ioOut), 32'h0000);
        @(negedge clk); drive(1, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0);
        @(negedge clk); drive(0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0); #2;
        check("rst_hold_dsr", 32'(ioOut), 32'h8000);
        check("rst_hold_data", 32'(dsp_data), 32'h00);
        check("rst_kbd_ready", 32'(kbd_ready), 32'd1);
        @(negedge clk); drive(0, 16'hFE00, 16'h0000, 0, 0, 0, 8'h00, 0); #2;
        check("rst_kbsr", 32'(ioOut), 32'h0000);
        check("rst_irq", 32'(kbd_irq), 32'd0);

        // Reset during SEND drops dsp_valid at that edge
        @(negedge clk); drive(0, 16'hFE06, 16'h0044, 1, 0, 0, 8'h00, 0);
        @(negedge clk); drive(1, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0); #2;
        check("send_valid", 32'(dsp_valid), 32'd1);
        @(negedge clk); drive(0, 16'hFE04, 16'h0000, 0, 0, 0, 8'h00, 0); #2;
        check("rst_send_valid", 32'(dsp_valid), 32'd0);
        check("rst_send_dsr", 32'(ioOut), 32'h8000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
